zoom_lerp_stage: RTL
====================

# zoom_lerp_stage

Bilinear-zoom interpolation stage. Consumes the registered sign-magnitude difference (p1 − p0) from the zoom subtractor stage together with the base pixel p0 and a fractional weight. Produces out = p0 + frac·(p1 − p0) / 2^FRAC_W, rounded and saturated. It is a 3-stage pipeline with valid/ready flow control, frame/line sideband passthrough and a sticky saturation flag.

## Interface
- WIDTH, 8: pixel component width
- FRAC_W, 8: interpolation weight width; weight range 0 .. 2^FRAC_W−1
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts beat this cycle
- base_in  input  WIDTH  p0, unsigned
- diff_in  input  WIDTH+1  {sign, magnitude}; sign=1 means p1<p0
- frac_in  input  FRAC_W  weight toward p1
- sof_in  input  1  first pixel of frame
- eol_in  input  1  last pixel of line
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts
- pix_out  output  WIDTH  interpolated pixel, unsigned
- sof_out  output  1  delayed sof_in
- eol_out  output  1  delayed eol_in
- sat_flag  output  1  sticky: saturation occurred since last accepted sof

## Operation
- Integration: the caller aligns base_in, frac_in and the sideband to the subtractor's registered output. This block adds no compensation delay.
- Beat accepted when in_valid & in_ready.
- Global advance enable: en = ~out_valid | out_ready. in_ready = en. All stage registers load only when en.
- S1:
  - prod = diff_in[WIDTH-1:0] × frac_in (WIDTH+FRAC_W bits, unsigned).
  - Register prod, base_in, diff_in[WIDTH], sof_in, eol_in.
  - v1 <= in_valid.
- S2:
  - d = (prod + 2^(FRAC_W−1)) >> FRAC_W, unsigned, at most 2^WIDTH−1.
  - r = sign ? base − d : base + d, computed signed at WIDTH+2 bits.
  - v2 <= v1.
- S3:
  - If r < 0: pix = 0. If r > 2^WIDTH−1: pix = 2^WIDTH−1. Otherwise pix = r[WIDTH-1:0].
  - sat = (r out of range).
  - Register pix_out, sof_out, eol_out. out_valid <= v2.
- Negative zero (diff_in = {1, 0}) is treated as +0.
- For legal inputs (p1 in range), saturation cannot occur. Saturation only triggers on malformed diff/base pairs.
- sat_flag:
  - Set when a valid beat leaves S3 with sat=1.
  - Cleared when a beat with sof_in=1 is accepted at the input.
  - If clear and set happen in the same cycle, set wins.
- Bubbles (v=0) advance like data. Data registers of invalid stages are don't-care. Sideband outputs are qualified by out_valid.

## Timing
- Latency is 3 cycles from acceptance to out_valid, when no stall occurs.
- Throughput is 1 beat/cycle while out_ready=1.
- Stall rules:
  - When out_valid=1 and out_ready=0, in_ready=0 in the same cycle (combinational path from out_ready).
  - During a stall every stage holds. pix_out, sof_out and eol_out remain stable.
- No beat is dropped, duplicated or reordered.
- Reset: at the first edge with rst=1, all of the following clear and stay clear while rst=1:
  - v1, v2, out_valid, pix_out, sof_out, eol_out, sat_flag
- Beats in flight at reset are discarded. in_ready=1 during and after reset (out_valid=0).
- out_valid may be asserted with out_ready low indefinitely. The output holds without timeout.

## Test plan
(WIDTH=8, FRAC_W=8)
- Positive lerp: base=100, diff={0,50}, frac=128 → pix_out=125, out_valid exactly 3 cycles after acceptance.
- Negative lerp: base=200, diff={1,100}, frac=64 → (6400+128)>>8=25 → pix_out=175.
- Extremes:
  - frac=0, base=77, diff={1,30} → 77.
  - base=0, diff={0,255}, frac=255 → 254.
  - diff={1,0}, base=9 → 9.
- Saturation:
  - Sequence: base=250, diff={0,20}, frac=255 → 270 → pix_out=255, sat_flag=1; it stays 1 across later beats.
  - Next accepted sof_in=1 beat clears it one cycle after acceptance.
  - Underflow: base=5, diff={1,20}, frac=255 → pix_out=0, sat_flag=1.
- Backpressure:
  - Stimulus: 8 consecutive beats with distinct values; out_ready low for 2 cycles while out_valid=1.
  - Required: in_ready low in exactly those cycles; outputs held; all 8 results in order with correct sof/eol.
- Reset mid-stream:
  - Stimulus: rst=1 for one cycle with 3 beats in flight and sat_flag=1.
  - Required: next cycle out_valid=0 and sat_flag=0; in-flight beats never appear; a fresh beat emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/zoom_lerp_stage.sv
// zoom_lerp_stage: bilinear-zoom interpolation, out = p0 + frac*(p1-p0)/2^FRAC_W.
// Three register stages (multiply, round/add, clamp) sharing one advance enable,
// so a downstream stall freezes the whole pipe and upstream sees in_ready low.
module zoom_lerp_stage #(
  parameter int WIDTH  = 8,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  base_in,
  input  logic [WIDTH:0]    diff_in,
  input  logic [FRAC_W-1:0] frac_in,
  input  logic              sof_in,
  input  logic              eol_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  pix_out,
  output logic              sof_out,
  output logic              eol_out,
  output logic              sat_flag
);

  localparam int PW = WIDTH + FRAC_W;
  // Signed result width: base +/- d spans -(2^WIDTH-1) .. 2*(2^WIDTH-1)
  localparam int RW = WIDTH + 2;
  localparam logic [PW-1:0] RND = PW'(1) << (FRAC_W - 1);

  logic en;

  // Stage 1 registers
  logic              v1;
  logic [PW-1:0]     s1_prod;
  logic [WIDTH-1:0]  s1_base;
  logic              s1_sign;
  logic              s1_sof;
  logic              s1_eol;

  // Stage 2 registers
  logic              v2;
  logic [RW-1:0]     s2_r;
  logic              s2_sof;
  logic              s2_eol;

  // Combinational intermediates
  logic [PW-1:0]     mag_ext;
  logic [PW-1:0]     frac_ext;
  logic [PW-1:0]     prod_c;
  logic [PW-1:0]     rnd_sum;
  logic [WIDTH-1:0]  d_c;
  logic [RW-1:0]     r_c;
  logic              under_c;
  logic              over_c;
  logic              sat_c;
  logic [WIDTH-1:0]  pix_c;
  logic              unused_rnd_bits;

  // Bubbles move like data, so a free output slot or a consuming sink advances all stages
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Magnitude-only multiply; the sign travels alongside and is applied after rounding,
  // which also makes a negative-zero difference behave as +0.
  assign mag_ext  = PW'(diff_in[WIDTH-1:0]);
  assign frac_ext = PW'(frac_in);
  assign prod_c   = mag_ext * frac_ext;

  // Stage 1: capture product and sideband
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (en) begin
      v1      <= in_valid;
      s1_prod <= prod_c;
      s1_base <= base_in;
      s1_sign <= diff_in[WIDTH];
      s1_sof  <= sof_in;
      s1_eol  <= eol_in;
    end
  end

  // Round half-up; prod+RND cannot overflow PW bits since prod <= (2^W-1)(2^F-1)
  assign rnd_sum         = s1_prod + RND;
  assign d_c             = rnd_sum[PW-1:FRAC_W];
  assign unused_rnd_bits = ^rnd_sum[FRAC_W-1:0];

  // Apply the sign in two's complement at RW bits so under/overflow stay visible
  always_comb begin
    r_c = {2'b00, s1_base};
    if (s1_sign) begin
      r_c = r_c - {2'b00, d_c};
    end else begin
      r_c = r_c + {2'b00, d_c};
    end
  end

  // Stage 2: register the unclamped signed result
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (en) begin
      v2     <= v1;
      s2_r   <= r_c;
      s2_sof <= s1_sof;
      s2_eol <= s1_eol;
    end
  end

  // Clamp: MSB set means negative; bit WIDTH set with MSB clear means above full scale
  always_comb begin
    under_c = s2_r[RW-1];
    over_c  = ~s2_r[RW-1] & s2_r[RW-2];
    sat_c   = under_c | over_c;
    pix_c   = s2_r[WIDTH-1:0];
    if (under_c) begin
      pix_c = '0;
    end else if (over_c) begin
      pix_c = '1;
    end
  end

  // Stage 3: output register; held while the sink stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pix_out   <= '0;
      sof_out   <= 1'b0;
      eol_out   <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      pix_out   <= pix_c;
      sof_out   <= s2_sof;
      eol_out   <= s2_eol;
    end
  end

  // Sticky saturation: set as a saturated beat enters the output slot, cleared when a
  // new frame is accepted; a simultaneous set takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (en & v2 & sat_c) begin
      sat_flag <= 1'b1;
    end else if (in_valid & en & sof_in) begin
      sat_flag <= 1'b0;
    end
  end

endmodule
